// File: rtl/tb9_sender_pkg.sv
// tb9_sender_types: shared types and constants for the tb9_sender block.
//   tb9_sender_state_t : FSM state encoding (ST_WAIT_CMD, ST_SEND)
//   TB9_START_VALUE    : default value loaded into the sequence register on reset
package tb9_sender_types;

    typedef enum logic [0:0] {
        ST_WAIT_CMD = 1'b0,
        ST_SEND     = 1'b1
    } tb9_sender_state_t;

    localparam logic signed [31:0] TB9_START_VALUE = 32'sd1337;

endpackage

// File: rtl/tb9_sender.sv
// tb9_sender: transmitting end of the integer blocking-port handshake.
// Accepts a count command, then emits that many consecutive 32-bit values
// from a persistent sequence register, one per accepted transfer.
//
// Handshake (both ports): a transfer happens at a posedge where _notify and
// _sync are both 1. _notify is a registered output and never depends on _sync
// combinationally; the peer drives _sync when it is willing to transfer.
//
// Ports:
//   clk           in   clock, all state updates on posedge
//   rst           in   asynchronous active-high reset
//   cmd_in        in   signed count of values to send (<= 0 is discarded)
//   cmd_in_sync   in   peer offers cmd_in this cycle
//   cmd_in_notify out  block ready to accept a command
//   b_out         out  outgoing data value
//   b_out_sync    in   peer ready to take b_out this cycle
//   b_out_notify  out  b_out valid, block requests a transfer
//   m_out         out  last value successfully delivered
//   busy          out  high while a burst is in progress
module tb9_sender
    import tb9_sender_types::*;
#(
    parameter logic signed [31:0] START_VALUE = TB9_START_VALUE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [31:0] cmd_in,
    input  logic               cmd_in_sync,
    output logic               cmd_in_notify,
    output logic signed [31:0] b_out,
    input  logic               b_out_sync,
    output logic               b_out_notify,
    output logic signed [31:0] m_out,
    output logic               busy
);

    tb9_sender_state_t  state;
    logic signed [31:0] seq;
    logic        [31:0] remaining;

    // In ST_SEND, b_out always equals seq, so seq + 1 is the next value to
    // present. The addition wraps in two's complement with no saturation.
    logic signed [31:0] seq_next;
    assign seq_next = seq + 32'sd1;

    always_ff @(posedge clk, posedge rst) begin
        if (rst) begin
            state         <= ST_WAIT_CMD;
            seq           <= START_VALUE;
            remaining     <= 32'd0;
            cmd_in_notify <= 1'b1;
            b_out_notify  <= 1'b0;
            b_out         <= 32'sd0;
            m_out         <= 32'sd0;
            busy          <= 1'b0;
        end else begin
            case (state)
                ST_WAIT_CMD: begin
                    // Non-positive counts are consumed and dropped without
                    // leaving this state or touching the output port.
                    if (cmd_in_notify && cmd_in_sync && (cmd_in > 32'sd0)) begin
                        remaining     <= $unsigned(cmd_in);
                        b_out         <= seq;
                        b_out_notify  <= 1'b1;
                        cmd_in_notify <= 1'b0;
                        busy          <= 1'b1;
                        state         <= ST_SEND;
                    end
                end

                ST_SEND: begin
                    if (b_out_notify && b_out_sync) begin
                        m_out     <= b_out;
                        seq       <= seq_next;
                        remaining <= remaining - 32'd1;
                        if (remaining == 32'd1) begin
                            // Last value delivered; b_out keeps showing it.
                            b_out_notify  <= 1'b0;
                            cmd_in_notify <= 1'b1;
                            busy          <= 1'b0;
                            state         <= ST_WAIT_CMD;
                        end else begin
                            b_out <= seq_next;
                        end
                    end
                end

                default: begin
                    state <= ST_WAIT_CMD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tb9_sender.sv
// Testbench for tb9_sender. A main instance runs against a scoreboard fed at
// command time; a second instance with a START_VALUE near the signed limit
// exercises the wrap of the sequence register.
module tb_tb9_sender;

    logic               clk;
    logic               rst;
    logic signed [31:0] cmd_in;
    logic               cmd_in_sync;
    logic               cmd_in_notify;
    logic signed [31:0] b_out;
    logic               b_out_sync;
    logic               b_out_notify;
    logic signed [31:0] m_out;
    logic               busy;

    logic signed [31:0] w_cmd_in;
    logic               w_cmd_in_sync;
    logic               w_cmd_in_notify;
    logic signed [31:0] w_b_out;
    logic               w_b_out_sync;
    logic               w_b_out_notify;
    logic signed [31:0] w_m_out;
    logic               w_busy;

    logic [31:0] exp_q[$];
    logic [31:0] model_seq;
    int          n_checks;
    int          n_pass;
    int          n_xfer;

    tb9_sender dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_in        (cmd_in),
        .cmd_in_sync   (cmd_in_sync),
        .cmd_in_notify (cmd_in_notify),
        .b_out         (b_out),
        .b_out_sync    (b_out_sync),
        .b_out_notify  (b_out_notify),
        .m_out         (m_out),
        .busy          (busy)
    );

    tb9_sender #(.START_VALUE(32'sh7FFFFFFF)) dut_wrap (
        .clk           (clk),
        .rst           (rst),
        .cmd_in        (w_cmd_in),
        .cmd_in_sync   (w_cmd_in_sync),
        .cmd_in_notify (w_cmd_in_notify),
        .b_out         (w_b_out),
        .b_out_sync    (w_b_out_sync),
        .b_out_notify  (w_b_out_notify),
        .m_out         (w_m_out),
        .busy          (w_busy)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Inputs change 1 time unit after the posedge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cmd_in      = 32'sd0;
        cmd_in_sync = 1'b0;
        b_out_sync  = 1'b0;
        rst         = 1'b1;
        exp_q.delete();
        model_seq   = 32'd1337;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // Offer one command; returns 1 time unit after the accepting edge.
    task automatic send_cmd(input int value);
        int k;
        k = 0;
        while (!cmd_in_notify && k < 50) begin
            step();
            k++;
        end
        check("cmd_ready", cmd_in_notify, 1'b1);
        cmd_in      = value;
        cmd_in_sync = 1'b1;
        for (int i = 0; i < value; i++) begin
            exp_q.push_back(model_seq);
            model_seq = model_seq + 32'd1;
        end
        step();
        cmd_in_sync = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 50) begin
            step();
            k++;
        end
        check("burst_done", busy, 1'b0);
    endtask

    // Scoreboard: inputs are stable between posedge+1 and the next posedge,
    // so a transfer seen here completes at the following posedge.
    always @(negedge clk) begin
        if (!rst && b_out_notify && b_out_sync) begin
            n_xfer++;
            check("xfer_expected", (exp_q.size() != 0), 1'b1);
            if (exp_q.size() != 0) check("b_out_value", b_out, exp_q.pop_front());
        end
    end

    initial begin
        int xfer0;
        n_checks      = 0;
        n_pass        = 0;
        n_xfer        = 0;
        w_cmd_in      = 32'sd0;
        w_cmd_in_sync = 1'b0;
        w_b_out_sync  = 1'b0;

        // Reset state
        cmd_in = 32'sd0; cmd_in_sync = 1'b0; b_out_sync = 1'b0; rst = 1'b1;
        model_seq = 32'd1337;
        #3;
        check("rst_cmd_notify", cmd_in_notify, 1'b1);
        check("rst_b_notify", b_out_notify, 1'b0);
        check("rst_m_out", m_out, 32'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_b_out", b_out, 32'd0);
        do_reset();

        // Burst of 3 with sync held high
        b_out_sync = 1'b1;
        send_cmd(3);
        check("b3_notify", b_out_notify, 1'b1);
        check("b3_first", b_out, 32'd1337);
        check("b3_busy", busy, 1'b1);
        check("b3_cmd_notify", cmd_in_notify, 1'b0);
        step();
        check("b3_second", b_out, 32'd1338);
        check("b3_m1", m_out, 32'd1337);
        step();
        check("b3_third", b_out, 32'd1339);
        step();
        check("b3_end_notify", b_out_notify, 1'b0);
        check("b3_end_m", m_out, 32'd1339);
        check("b3_end_cmd_notify", cmd_in_notify, 1'b1);
        check("b3_end_hold", b_out, 32'd1339);
        check("b3_end_busy", busy, 1'b0);

        // Burst of 2 with stalling sink: sync 0,1,0,0,1
        do_reset();
        xfer0 = n_xfer;
        send_cmd(2);
        check("st_first", b_out, 32'd1337);
        b_out_sync = 1'b0; step();
        check("st_hold0", b_out, 32'd1337);
        check("st_m0", m_out, 32'd0);
        b_out_sync = 1'b1; step();
        check("st_next", b_out, 32'd1338);
        check("st_m1", m_out, 32'd1337);
        b_out_sync = 1'b0; step();
        b_out_sync = 1'b0; step();
        check("st_hold1", b_out, 32'd1338);
        check("st_notify_hold", b_out_notify, 1'b1);
        b_out_sync = 1'b1; step();
        check("st_end_notify", b_out_notify, 1'b0);
        check("st_end_m", m_out, 32'd1338);
        check("st_xfer_count", n_xfer - xfer0, 2);

        // Non-positive commands are discarded
        do_reset();
        b_out_sync = 1'b1;
        send_cmd(0);
        check("z_notify", b_out_notify, 1'b0);
        check("z_busy", busy, 1'b0);
        check("z_cmd_notify", cmd_in_notify, 1'b1);
        send_cmd(-5);
        step();
        check("n_notify", b_out_notify, 1'b0);
        check("n_cmd_notify", cmd_in_notify, 1'b1);
        send_cmd(1);
        check("one_value", b_out, 32'd1337);
        wait_idle();
        check("one_m", m_out, 32'd1337);

        // Two bursts: seq persists across commands
        do_reset();
        b_out_sync = 1'b1;
        send_cmd(2);
        wait_idle();
        check("p1_m", m_out, 32'd1338);
        send_cmd(2);
        check("p2_first", b_out, 32'd1339);
        wait_idle();
        check("p2_m", m_out, 32'd1340);

        // Wrap instance: 7FFFFFFF -> 80000000
        w_cmd_in = 32'sd2; w_cmd_in_sync = 1'b1; w_b_out_sync = 1'b1;
        step();
        w_cmd_in_sync = 1'b0;
        check("w_first", w_b_out, 32'h7FFFFFFF);
        check("w_notify", w_b_out_notify, 1'b1);
        step();
        check("w_second", w_b_out, 32'h80000000);
        check("w_m1", w_m_out, 32'h7FFFFFFF);
        step();
        check("w_end_notify", w_b_out_notify, 1'b0);
        check("w_end_m", w_m_out, 32'h80000000);

        // Reset after the first of four transfers
        do_reset();
        b_out_sync = 1'b1;
        send_cmd(4);
        step();
        check("mr_m1", m_out, 32'd1337);
        rst = 1'b1;
        #1;
        exp_q.delete();
        model_seq = 32'd1337;
        check("mr_b_notify", b_out_notify, 1'b0);
        check("mr_busy", busy, 1'b0);
        check("mr_m_out", m_out, 32'd0);
        check("mr_b_out", b_out, 32'd0);
        check("mr_cmd_notify", cmd_in_notify, 1'b1);
        #2;
        rst = 1'b0;
        step();
        step();
        check("mr_quiet", b_out_notify, 1'b0);
        send_cmd(1);
        check("mr_new", b_out, 32'd1337);
        wait_idle();
        check("mr_new_m", m_out, 32'd1337);

        step();
        check("queue_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tb9_sender.md
# tb9_sender

Transmitting end of the integer blocking-port handshake used by the TestBasic9-family receivers. It accepts a count command on a blocking input port. It then emits that many consecutive 32-bit values, one per accepted transfer, on a blocking output port. A master output mirrors the last value delivered. It sits upstream of any block exposing an integer blocking input with `_sync`/`_notify` handshake.

## Interface
Parameters:
- START_VALUE, 1337: value of the sequence register after reset.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-high.
- cmd_in  input  32 (integer, signed)  number of values to send.
- cmd_in_sync  input  1  peer offers cmd_in this cycle.
- cmd_in_notify  output  1  block ready to accept a command.
- b_out  output  32 (integer, signed)  outgoing data.
- b_out_sync  input  1  peer ready to take b_out this cycle.
- b_out_notify  output  1  b_out valid; block requests transfer.
- m_out  output  32 (integer, signed)  last value successfully delivered.
- busy  output  1  high while a burst is in progress.

## Operation
- Handshake rule, both ports: a transfer occurs at a posedge where `_notify` and `_sync` are both 1. All outputs are registered. `_notify` never depends combinationally on `_sync`.
- Internal registers:
  - `seq`: 32-bit, reset START_VALUE.
  - `remaining`: 32-bit unsigned.
  - `state`.
- State ST_WAIT_CMD:
  - cmd_in_notify=1, b_out_notify=0, busy=0.
  - On command transfer with cmd_in > 0: remaining <= cmd_in, b_out <= seq, b_out_notify <= 1, cmd_in_notify <= 0, busy <= 1, go to ST_SEND.
  - On command transfer with cmd_in <= 0: command consumed and discarded, stay in ST_WAIT_CMD, cmd_in_notify stays 1, no output activity.
- State ST_SEND:
  - b_out_notify=1, b_out stable until transferred.
  - On data transfer: m_out <= b_out, seq <= seq+1, remaining <= remaining-1.
    - If remaining==1: b_out_notify <= 0, cmd_in_notify <= 1, busy <= 0, go to ST_WAIT_CMD. b_out holds the last value.
    - Otherwise: b_out <= seq+1, b_out_notify stays 1.
  - b_out_sync=0: hold everything.
- `seq` persists across bursts and is not reloaded per command.
- Arithmetic: seq+1 is 32-bit two's-complement with wrap, so 32'h7FFFFFFF -> 32'h80000000. No saturation.
- cmd_in_sync is ignored in ST_SEND.

## Timing
- Reset values:
  - cmd_in_notify=1, b_out_notify=0, b_out=0, m_out=0, busy=0.
  - seq=START_VALUE, remaining=0, state=ST_WAIT_CMD.
- Reset mid-burst: immediate return to the reset values. The partial burst is abandoned. No further b_out_notify until a new command arrives.
- Latency:
  - Command accept edge -> b_out_notify=1 on the next cycle.
  - First data transfer possible at the posedge after that.
- Throughput: with b_out_sync held 1, one value per cycle. N values take N consecutive transfer edges.
- Burst end -> cmd_in_notify=1 in the cycle after the last transfer. The next command can be accepted at the following edge. There is one idle cycle between bursts on b_out.
- m_out updates on the same edge as each transfer, so it is visible one cycle after the transfer edge.

## Structure
- Package `tb9_sender_types`:
  - enum `tb9_sender_state_t` {ST_WAIT_CMD, ST_SEND}.
  - constant `TB9_START_VALUE` = 1337.
- Single flat module with one `always_ff @(posedge clk, posedge rst)` process. No sub-module needed.

## Test plan
- Reset -> cmd_in_notify=1, b_out_notify=0, m_out=0, busy=0.
- Command cmd_in=3, b_out_sync held 1 -> b_out sequence 1337, 1338, 1339 on three consecutive edges. Then b_out_notify=0, m_out=1339, cmd_in_notify=1.
- Command cmd_in=2 with b_out_sync toggling 0,1,0,0,1 -> b_out holds 1337 while sync=0. Exactly two transfers, values 1337 then 1338.
- Command cmd_in=0, then cmd_in=-5 -> both consumed, no b_out_notify, seq unchanged. A following cmd_in=1 emits 1337.
- Two bursts of 2 -> values 1337, 1338, then 1339, 1340, confirming seq persists across bursts.
- Wrap: force seq to 32'h7FFFFFFF (START_VALUE override), cmd_in=2 -> b_out 2147483647 then -2147483648.
- Reset asserted after the first of four transfers -> outputs return to reset values. A new cmd_in=1 emits 1337.
